// File: rtl/pc_seq_if.sv
// Bus between control/branch logic and the program counter sequencer.
// master: control side driving redirects/handshake; slave: the sequencer.
interface pc_seq_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              pc_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_target;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_offset;
    logic              call_en;
    logic              ret_en;
    logic              halt;
    logic              resume;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_plus_inc;
    logic              pc_valid;
    logic              halted;
    logic              ras_empty;

    modport master (
        output pc_ready, jump_en, jump_target, branch_taken, branch_offset,
        output call_en, ret_en, halt, resume,
        input  pc_out, pc_plus_inc, pc_valid, halted, ras_empty
    );

    modport slave (
        input  pc_ready, jump_en, jump_target, branch_taken, branch_offset,
        input  call_en, ret_en, halt, resume,
        output pc_out, pc_plus_inc, pc_valid, halted, ras_empty
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch address, sequential advance on valid/ready,
// jump/branch/return redirects, halt/resume FSM.
// Optional return-address stack enabled by defining macro PC_RAS_EN.
module pc_sequencer #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int unsigned       RAS_DEPTH   = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_seq_if.slave  bus
);

    // Clears the low log2(INSTR_BYTES) bits of redirect results.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INSTR_BYTES) - ADDR_W'(1));

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty_w;
    logic              ras_push;
    logic              ras_pop;

    assign pc_plus         = pc_q + ADDR_W'(INSTR_BYTES);
    assign bus.pc_out      = pc_q;
    assign bus.pc_plus_inc = pc_plus;
    assign bus.pc_valid    = (state_q == StRun);
    assign bus.halted      = (state_q == StHalt);
    assign bus.ras_empty   = ras_empty_w;

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC and stack control; redirects are only honoured in RUN.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (bus.halt) state_d = StHalt;
                if (bus.jump_en) begin
                    pc_d     = bus.jump_target & ALIGN_MASK;
                    ras_push = bus.call_en;
                end else if (bus.branch_taken) begin
                    pc_d = (pc_q + bus.branch_offset) & ALIGN_MASK;
                end else if (bus.ret_en && !ras_empty_w) begin
                    pc_d    = ras_top & ALIGN_MASK;
                    ras_pop = 1'b1;
                end else if (bus.pc_ready) begin
                    pc_d = pc_plus;
                end
            end
            StHalt: begin
                if (bus.resume && !bus.halt) state_d = StRun;
            end
            default: state_d = StBoot;
        endcase
    end

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr_q;
    logic [CNT_W-1:0]  ras_cnt_q;

    // ras_ptr_q points at the next free slot; when full it points at the oldest entry.
    assign ras_top     = ras_mem[ras_ptr_q - PTR_W'(1)];
    assign ras_empty_w = (ras_cnt_q == '0);

    // Stack pointer and occupancy; a push when full overwrites the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (ras_push) begin
            ras_ptr_q <= ras_ptr_q + PTR_W'(1);
            if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + CNT_W'(1);
        end else if (ras_pop) begin
            ras_ptr_q <= ras_ptr_q - PTR_W'(1);
            ras_cnt_q <= ras_cnt_q - CNT_W'(1);
        end
    end

    // Return-address storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (ras_push) ras_mem[ras_ptr_q] <= pc_plus;
    end
`else
    logic unused_ras;

    assign ras_top     = '0;
    assign ras_empty_w = 1'b1;
    assign unused_ras  = ^{ras_push, ras_pop};
`endif

endmodule
